// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and op-class definitions for the cpu sequencer
package cpu_pkg;

  localparam int unsigned MUL_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MUL    = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_MUL,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // adm and sbm ignore opcode bit 0; only bits [4:1] of those two are compared
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADR = 5'b00001;
  localparam logic [4:0] OP_ADM = 5'b00010;
  localparam logic [4:0] OP_ADI = 5'b00100;
  localparam logic [4:0] OP_SBR = 5'b00101;
  localparam logic [4:0] OP_SBM = 5'b00110;
  localparam logic [4:0] OP_SBI = 5'b01000;
  localparam logic [4:0] OP_MLR = 5'b01001;
  localparam logic [4:0] OP_XSL = 5'b01010;
  localparam logic [4:0] OP_XSR = 5'b01011;
  localparam logic [4:0] OP_BBO = 5'b01100;
  localparam logic [4:0] OP_STK = 5'b01101;
  localparam logic [4:0] OP_LDR = 5'b01110;
  localparam logic [4:0] OP_STI = 5'b01111;
  localparam logic [4:0] OP_JMR = 5'b11100;
  localparam logic [4:0] OP_HLT = 5'b11111;

  localparam int unsigned STK_POP_BIT = 6;

endpackage

// File: rtl/op_classify.sv
// rtl/op_classify.sv - combinational opcode to instruction-class decoder
module op_classify
  import cpu_pkg::*;
(
  input  logic [4:0] op,
  input  logic       stk_pop,
  output op_class_e  op_class
);

  logic is_alu;

  assign is_alu = (op == OP_ADR) || (op[4:1] == OP_ADM[4:1]) || (op == OP_ADI) ||
                  (op == OP_SBR) || (op[4:1] == OP_SBM[4:1]) || (op == OP_SBI) ||
                  (op == OP_XSL) || (op == OP_XSR) || (op == OP_BBO);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (is_alu)                                     op_class = CLS_ALU;
    else if (op == OP_MLR)                          op_class = CLS_MUL;
    else if (op == OP_LDR || (op == OP_STK && stk_pop)) op_class = CLS_LOAD;
    else if (op == OP_STI || op == OP_STK)          op_class = CLS_STORE;
    else if (op == OP_JMR)                          op_class = CLS_JUMP;
    else if (op == OP_NOP)                          op_class = CLS_NOP;
    else if (op == OP_HLT)                          op_class = CLS_HALT;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute control FSM driving memory and datapath strobes
module cpu_sequencer #(
  parameter int unsigned MUL_CYCLES = cpu_pkg::MUL_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic [15:0] IR,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        ADDR_SEL,
  output logic        REG_WE,
  output logic        FLAG_WE,
  output logic        PC_INC,
  output logic        PC_LOAD,
  output logic        BUSY_MUL,
  output logic        ILLEGAL,
  output logic        HALTED,
  output logic [2:0]  STATE
);
  import cpu_pkg::*;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;
  // run_q keeps the first fetch request off until one clock after reset release
  logic        run_q, run_d;
  op_class_e   op_class;

  op_classify u_op_classify (
    .op       (ir_q[15:11]),
    .stk_pop  (ir_q[STK_POP_BIT]),
    .op_class (op_class)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_FETCH;
      ir_q    <= 16'h0000;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    run_d    = 1'b1;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    ADDR_SEL = 1'b0;
    REG_WE   = 1'b0;
    FLAG_WE  = 1'b0;
    PC_INC   = 1'b0;
    PC_LOAD  = 1'b0;
    BUSY_MUL = 1'b0;
    ILLEGAL  = 1'b0;
    HALTED   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          MEM_REQ = 1'b1;
          if (MEM_READY) begin
            ir_d    = MEM_RDATA;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        unique case (op_class)
          CLS_ALU: begin
            REG_WE  = 1'b1;
            FLAG_WE = 1'b1;
            PC_INC  = 1'b1;
          end
          CLS_MUL: begin
            cnt_d   = MUL_LOAD;
            state_d = ST_MUL;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_JUMP: PC_LOAD = 1'b1;
          CLS_NOP:  PC_INC  = 1'b1;
          CLS_HALT: state_d = ST_HALT;
          default: begin
            PC_INC  = 1'b1;
            ILLEGAL = 1'b1;
          end
        endcase
      end
      ST_MUL: begin
        BUSY_MUL = 1'b1;
        if (cnt_q == 4'd0) begin
          REG_WE  = 1'b1;
          FLAG_WE = 1'b1;
          PC_INC  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_MEM: begin
        MEM_REQ  = 1'b1;
        ADDR_SEL = 1'b1;
        MEM_WE   = (op_class == CLS_STORE);
        if (MEM_READY) begin
          if (op_class == CLS_STORE) begin
            PC_INC  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        REG_WE  = 1'b1;
        PC_INC  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: HALTED = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  assign IR    = ir_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer per-cycle control outputs
module tb_cpu_sequencer;

  localparam int MULC = 4;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, asel, rwe, fwe, inc, ld, busy, ill, hlt;
  } obs_t;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic [15:0] MEM_RDATA = 16'h0000;
  logic        MEM_READY = 1'b0;
  logic [15:0] IR;
  logic        MEM_REQ, MEM_WE, ADDR_SEL, REG_WE, FLAG_WE, PC_INC, PC_LOAD;
  logic        BUSY_MUL, ILLEGAL, HALTED;
  logic [2:0]  STATE;

  int   checks = 0;
  int   passes = 0;
  obs_t sb[$];

  cpu_sequencer #(.MUL_CYCLES(MULC)) dut (
    .CLK(CLK), .nRESET(nRESET), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
    .IR(IR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .ADDR_SEL(ADDR_SEL),
    .REG_WE(REG_WE), .FLAG_WE(FLAG_WE), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD),
    .BUSY_MUL(BUSY_MUL), .ILLEGAL(ILLEGAL), .HALTED(HALTED), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    return '{STATE, MEM_REQ, MEM_WE, ADDR_SEL, REG_WE, FLAG_WE, PC_INC, PC_LOAD,
             BUSY_MUL, ILLEGAL, HALTED};
  endfunction

  function automatic obs_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic asel, input logic rwe, input logic fwe,
                              input logic inc, input logic ld, input logic busy,
                              input logic ill, input logic hlt);
    return '{st, req, we, asel, rwe, fwe, inc, ld, busy, ill, hlt};
  endfunction

  // 0 alu, 1 mul, 2 load, 3 store, 4 jump, 5 nop, 6 halt, 7 illegal
  function automatic int bench_class(input logic [15:0] i);
    casez (i[15:11])
      5'b00001, 5'b0001?, 5'b00100, 5'b00101, 5'b0011?,
      5'b01000, 5'b01010, 5'b01011, 5'b01100: return 0;
      5'b01001: return 1;
      5'b01110: return 2;
      5'b01111: return 3;
      5'b01101: return i[6] ? 2 : 3;
      5'b11100: return 4;
      5'b00000: return 5;
      5'b11111: return 6;
      default:  return 7;
    endcase
  endfunction

  task automatic check_obs(input string tag, input obs_t exp);
    obs_t o;
    o = observe();
    checks++;
    assert (o === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, o, exp);
    end
  endtask

  task automatic check_ir(input string tag, input logic [15:0] exp);
    checks++;
    assert (IR === exp) begin
      passes++;
    end else begin
      $error("FAIL %s IR: observed %h expected %h", tag, IR, exp);
    end
  endtask

  task automatic expect_instr(input logic [15:0] instr, input int waits);
    int c;
    c = bench_class(instr);
    sb.push_back(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (c)
      0: sb.push_back(mk(3'd2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      1: begin
        sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= MULC; i++)
          sb.push_back(mk(3'd3, 0, 0, 0, i == MULC, i == MULC, i == MULC, 0, 1, 0, 0));
      end
      2: begin
        sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= waits; i++)
          sb.push_back(mk(3'd4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(3'd5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      end
      3: begin
        sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= waits; i++)
          sb.push_back(mk(3'd4, 1, 1, 1, 0, 0, i == waits, 0, 0, 0, 0));
      end
      4: sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      5: sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      6: begin
        sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
          sb.push_back(mk(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      default: sb.push_back(mk(3'd2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    endcase
  endtask

  // Called just after a rising edge; drives one cycle, compares at the falling edge.
  task automatic run(input string tag, input logic [15:0] instr, input int waits,
                     input int limit);
    int k = 0;
    while (sb.size() > 0 && k < limit) begin
      MEM_RDATA = instr;
      MEM_READY = !(k >= 3 && k < 3 + waits);
      @(negedge CLK);
      check_obs($sformatf("%s cyc%0d", tag, k), sb.pop_front());
      @(posedge CLK);
      #1;
      k++;
    end
  endtask

  task automatic do_instr(input string tag, input logic [15:0] instr, input int waits);
    expect_instr(instr, waits);
    run(tag, instr, waits, 1000);
    check_ir(tag, instr);
  endtask

  task automatic mid_reset(input string tag);
    nRESET = 1'b0;
    #1;
    check_obs({tag, " async"}, '0);
    check_ir({tag, " async"}, 16'h0000);
    sb.delete();
    @(negedge CLK);
    check_obs({tag, " held"}, '0);
    nRESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    MEM_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check_obs("reset", '0);
    check_ir("reset", 16'h0000);
    nRESET = 1'b1;
    #1;
    check_obs("release", '0);
    @(posedge CLK);
    #1;

    do_instr("adr", 16'h0800, 0);
    do_instr("adm", 16'h1FFF, 0);
    do_instr("sbm", 16'h3800, 0);
    do_instr("bbo", 16'h6123, 0);
    do_instr("mlr", 16'h4800, 0);
    do_instr("ldr", 16'h7000, 3);
    do_instr("stk_pop", 16'h6840, 0);
    do_instr("stk_push", 16'h6800, 1);
    do_instr("sti", 16'h7800, 2);
    do_instr("jmr", 16'hE000, 0);
    do_instr("nop", 16'h0000, 0);
    do_instr("illegal", 16'h8000, 0);

    expect_instr(16'h4800, 0);
    run("mlr_int", 16'h4800, 0, 5);
    mid_reset("rst_mul");
    do_instr("after_mul_rst", 16'h0800, 0);

    expect_instr(16'h7000, 10);
    run("ldr_int", 16'h7000, 10, 6);
    mid_reset("rst_mem");
    do_instr("after_mem_rst", 16'h2000, 0);

    do_instr("hlt", 16'hF800, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, is the number of EXEC cycles a multiply (mlr) occupies; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 nRESET  input  1  reset, asynchronous and active-low.
REQ-004 MEM_RDATA  input  16  instruction or data word from memory.
REQ-005 MEM_READY  input  1  memory handshake; completes the current MEM_REQ transfer in the cycle it is sampled high.
REQ-006 IR  output  16  instruction register, fed to the ALU decoder's INSTR input.
REQ-007 MEM_REQ  output  1  memory transfer request, held high until MEM_READY.
REQ-008 MEM_WE  output  1  write qualifier for MEM_REQ; 0 means read.
REQ-009 ADDR_SEL  output  1  address source: 0 = PC, 1 = ALU result.
REQ-010 REG_WE  output  1  register-file write strobe, one cycle.
REQ-011 FLAG_WE  output  1  CARRY flag update strobe, one cycle.
REQ-012 PC_INC  output  1  PC increment strobe, one cycle.
REQ-013 PC_LOAD  output  1  PC load-from-ALU strobe, one cycle (jmr).
REQ-014 BUSY_MUL  output  1  high while a multiply is in progress.
REQ-015 ILLEGAL  output  1  one-cycle pulse on an undefined opcode.
REQ-016 HALTED  output  1  high in HALT state.
REQ-017 STATE  output  3  current state encoding, for debug.

Function
REQ-018 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MUL=3, MEM=4, WB=5, HALT=6.
REQ-019 The opcode SHALL be IR[15:11]: adr 00001, adm 0001x, adi 00100, sbr 00101, sbm 0011x, sbi 01000, mlr 01001, xsl 01010, xsr 01011, bbo 01100, stk 01101, ldr 01110, sti 01111, jmr 11100, NOP 00000, HLT 11111.
REQ-020 FETCH SHALL drive MEM_REQ=1, MEM_WE=0, ADDR_SEL=0; on MEM_READY it loads IR from MEM_RDATA and goes to DECODE. MEM_READY high in the first FETCH cycle SHALL be accepted with no wait state.
REQ-021 DECODE SHALL last exactly one cycle, with all strobes low, then go to EXEC.
REQ-022 In EXEC, ALU opcodes except mlr (adr, adm, adi, sbr, sbm, sbi, xsl, xsr, bbo) SHALL pulse REG_WE, FLAG_WE and PC_INC together, then go to FETCH. Each such instruction totals 3 cycles at zero wait states.
REQ-023 mlr SHALL go from EXEC to MUL with BUSY_MUL=1 and a 4-bit counter loaded with MUL_CYCLES-1. The counter decrements each cycle; at 0 the FSM pulses REG_WE, FLAG_WE and PC_INC, clears BUSY_MUL and goes to FETCH. With MUL_CYCLES=1 the write SHALL occur in the first MUL cycle.
REQ-024 ldr, and stk with IR[6]=1 (pop), SHALL go EXEC->MEM with MEM_REQ=1, MEM_WE=0, ADDR_SEL=1. On MEM_READY they go to WB, which pulses REG_WE and PC_INC and returns to FETCH.
REQ-025 sti, and stk with IR[6]=0 (push), SHALL go EXEC->MEM with MEM_REQ=1, MEM_WE=1, ADDR_SEL=1. On MEM_READY they pulse PC_INC and return to FETCH; REG_WE stays low.
REQ-026 MEM_REQ, MEM_WE and ADDR_SEL SHALL be held stable while MEM_READY is low, for an unbounded number of wait cycles.
REQ-027 jmr SHALL pulse PC_LOAD in EXEC, with PC_INC low, then go to FETCH.
REQ-028 NOP SHALL pulse PC_INC in EXEC only.
REQ-029 Undefined opcodes SHALL behave as NOP and additionally pulse ILLEGAL in EXEC.
REQ-030 HLT SHALL go to HALT with PC_INC low. HALT holds HALTED=1 with all strobes low and is left only by reset.
REQ-031 PC_INC and PC_LOAD SHALL never be high in the same cycle, and exactly one of the two, or neither (HLT), fires per instruction.

Reset
REQ-032 While nRESET=0 the FSM SHALL be in FETCH with IR=0x0000, the counter at 0, and all outputs low (STATE=0). Reset takes effect asynchronously, including in the middle of MEM or MUL.
REQ-033 The first MEM_REQ SHALL assert in the first cycle after nRESET rises.

Structure
REQ-034 State encodings, opcode constants and the MUL_CYCLES default SHALL live in a shared package, cpu_pkg.
REQ-035 The opcode classification (alu/mul/load/store/jump/nop/halt/illegal) SHALL be one combinational sub-module, op_classify, with the FSM kept in cpu_sequencer.

Verification
REQ-036 adr with MEM_READY tied high -> STATE sequence 0,1,2,0; REG_WE, FLAG_WE and PC_INC high together in cycle 3 only.
REQ-037 mlr with MUL_CYCLES=4 -> BUSY_MUL high for 4 cycles; REG_WE in the 4th MUL cycle; 7 cycles in total.
REQ-038 ldr with MEM_READY low for 3 cycles in MEM -> MEM_REQ=1, MEM_WE=0, ADDR_SEL=1 held for 4 cycles; WB pulses REG_WE and PC_INC.
REQ-039 sti, then jmr -> MEM_WE=1 during MEM with REG_WE low; jmr gives PC_LOAD=1 and PC_INC=0.
REQ-040 Opcode 10000 -> ILLEGAL and PC_INC pulse in EXEC. HLT 0xF800 -> HALTED=1 and no strobes for 10 cycles.
REQ-041 nRESET driven low mid-MUL and mid-MEM -> outputs 0 and STATE=0 immediately; fetch restarts the cycle after release.
